// File: rtl/mmio_timer_responder_if.sv
// Memory-mapped bus connection between the CPU data port and the timer responder.
// The CPU side drives address/strobe/data; the timer side returns read data, decode hit and irq.
interface mmio_timer_responder_if;
   logic [31:0] address;
   logic        wr;
   logic [31:0] datain;
   logic [31:0] dataout;
   logic        hit;
   logic        irq;

   modport master (
      output address,
      output wr,
      output datain,
      input  dataout,
      input  hit,
      input  irq
   );

   modport slave (
      input  address,
      input  wr,
      input  datain,
      output dataout,
      output hit,
      output irq
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level interrupt.
// Register window of four words at BASE: CTRL, LOAD, COUNT (read-only), STATUS (EXP, W1C).
module mmio_timer_responder #(
   parameter logic [31:0] BASE = 32'hFFFF_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   mmio_timer_responder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      EXPIRE = 2'd2
   } state_t;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_LOAD   = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   state_t      state_reg, state_next;
   logic [2:0]  ctrl_reg, ctrl_next;
   logic [31:0] load_reg, load_next;
   logic [31:0] count_reg, count_next;
   logic        exp_reg, exp_next;
   logic [31:0] dataout_reg, dataout_next;
   logic        irq_reg;

   logic        hit;
   logic [1:0]  offset;
   logic        wr_en;
   logic        rd_en;
   logic        unused_addr_bits;

   assign hit              = (bus.address[31:4] == BASE[31:4]);
   assign offset           = bus.address[3:2];
   assign wr_en            = hit & bus.wr;
   assign rd_en            = hit & ~bus.wr;
   assign unused_addr_bits = ^bus.address[1:0];

   assign bus.hit     = hit;
   assign bus.dataout = dataout_reg;
   assign bus.irq     = irq_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         ctrl_reg    <= 3'd0;
         load_reg    <= 32'd0;
         count_reg   <= 32'd0;
         exp_reg     <= 1'b0;
         dataout_reg <= 32'd0;
         irq_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ctrl_reg    <= ctrl_next;
         load_reg    <= load_next;
         count_reg   <= count_next;
         exp_reg     <= exp_next;
         dataout_reg <= dataout_next;
         irq_reg     <= exp_reg & ctrl_reg[2];
      end
   end

   always_comb begin
      ctrl_next    = ctrl_reg;
      load_next    = load_reg;
      count_next   = count_reg;
      exp_next     = exp_reg;
      dataout_next = 32'd0;
      state_next   = state_reg;

      // Hardware counter action, driven by the state the timer is in this cycle.
      case (state_reg)
         RUN: begin
            count_next = count_reg - 32'd1;
         end
         EXPIRE: begin
            exp_next = 1'b1;
            if (ctrl_reg[1]) begin
               count_next = load_reg;
            end else begin
               ctrl_next[0] = 1'b0;
            end
         end
         default: begin
         end
      endcase

      // Bus writes override the hardware action, except that an expiry beats a W1C.
      if (wr_en) begin
         case (offset)
            OFF_CTRL: ctrl_next = bus.datain[2:0];
            OFF_LOAD: begin
               load_next  = bus.datain;
               count_next = bus.datain;
            end
            OFF_STATUS: begin
               if (bus.datain[0] && (state_reg != EXPIRE)) begin
                  exp_next = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end

      if (!ctrl_next[0]) begin
         state_next = IDLE;
      end else if (count_next == 32'd0) begin
         state_next = EXPIRE;
      end else begin
         state_next = RUN;
      end

      if (rd_en) begin
         case (offset)
            OFF_CTRL:   dataout_next = {29'd0, ctrl_reg};
            OFF_LOAD:   dataout_next = load_reg;
            OFF_COUNT:  dataout_next = count_reg;
            OFF_STATUS: dataout_next = {31'd0, exp_reg};
            default:    dataout_next = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: directed scenarios plus a randomized run,
// all compared against a register-level behavioural model of the timer.
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE    = 32'hFFFF_0000;
   localparam logic [31:0] A_CTRL  = BASE + 32'd0;
   localparam logic [31:0] A_LOAD  = BASE + 32'd4;
   localparam logic [31:0] A_COUNT = BASE + 32'd8;
   localparam logic [31:0] A_STAT  = BASE + 32'd12;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   mmio_timer_responder_if bus ();

   mmio_timer_responder #(.BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: architectural registers and outputs.
   logic [2:0]  m_ctrl;
   logic [31:0] m_load;
   logic [31:0] m_count;
   logic        m_exp;
   logic [31:0] m_dout;
   logic        m_irq;

   task automatic model_reset();
      m_ctrl = 3'd0; m_load = 32'd0; m_count = 32'd0;
      m_exp = 1'b0; m_dout = 32'd0; m_irq = 1'b0;
   endtask

   task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
      logic        h;
      logic        expiry;
      logic [2:0]  n_ctrl;
      logic [31:0] n_load, n_count, rv;
      logic        n_exp;
      h       = (a[31:4] == BASE[31:4]);
      expiry  = m_ctrl[0] && (m_count == 0);
      n_ctrl  = m_ctrl; n_load = m_load; n_count = m_count; n_exp = m_exp;
      if (m_ctrl[0]) begin
         if (m_count != 0) n_count = m_count - 1;
         else begin
            n_exp = 1'b1;
            if (m_ctrl[1]) n_count = m_load;
            else n_ctrl[0] = 1'b0;
         end
      end
      if (h && w) begin
         case (a[3:2])
            2'd0: n_ctrl = d[2:0];
            2'd1: begin n_load = d; n_count = d; end
            2'd3: if (d[0] && !expiry) n_exp = 1'b0;
            default: ;
         endcase
      end
      case (a[3:2])
         2'd0: rv = {29'd0, m_ctrl};
         2'd1: rv = m_load;
         2'd2: rv = m_count;
         default: rv = {31'd0, m_exp};
      endcase
      m_dout  = (h && !w) ? rv : 32'd0;
      m_irq   = m_exp & m_ctrl[2];
      m_ctrl  = n_ctrl; m_load = n_load; m_count = n_count; m_exp = n_exp;
   endtask

   task automatic bus_cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
      bus.address = a; bus.wr = w; bus.datain = d;
      @(posedge clk);
      model_step(a, w, d);
      #1;
   endtask

   task automatic test_reset();
      bus.address = A_CTRL; bus.wr = 1'b0; bus.datain = 32'd0;
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      #2;
      n_checks++;
      if (bus.dataout !== 32'd0 || bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: dataout=%h irq=%b required 0/0", bus.dataout, bus.irq);
      end
      n_checks++;
      if (bus.hit !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_in_reset: hit=%b required 1", bus.hit);
      end
      bus.address = 32'h0000_0010;
      #1;
      n_checks++;
      if (bus.hit !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_in_reset: hit=%b required 0", bus.hit);
      end
      @(posedge clk); #3 reset = 1'b1;
      $display("reset released");
   endtask

   task automatic test_readback();
      bus_cycle(A_LOAD, 1'b1, 32'd5);
      bus_cycle(A_COUNT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd5) begin
         n_fail++;
         $display("FAIL readback_count: dataout=%h required 5", bus.dataout);
      end
      bus_cycle(A_CTRL, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd0) begin
         n_fail++;
         $display("FAIL readback_ctrl: dataout=%h required 0", bus.dataout);
      end
      bus_cycle(A_LOAD + 32'd3, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd5) begin
         n_fail++;
         $display("FAIL readback_load: dataout=%h required 5", bus.dataout);
      end
      bus.address = 32'h0000_0010; bus.wr = 1'b0;
      #1;
      n_checks++;
      if (bus.hit !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_hit: hit=%b required 0", bus.hit);
      end
      bus_cycle(32'h0000_0010, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd0) begin
         n_fail++;
         $display("FAIL miss_dataout: dataout=%h required 0", bus.dataout);
      end
      $display("readback done");
   endtask

   task automatic test_oneshot();
      bus_cycle(A_LOAD, 1'b1, 32'd3);
      bus_cycle(A_CTRL, 1'b1, 32'd5);
      for (int i = 0; i < 4; i++) begin
         bus_cycle(A_COUNT, 1'b0, 32'd0);
         n_checks++;
         if (bus.dataout !== 32'(3 - i)) begin
            n_fail++;
            $display("FAIL oneshot_count[%0d]: dataout=%h required %h", i, bus.dataout, 32'(3 - i));
         end
      end
      bus_cycle(A_STAT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd1 || bus.irq !== 1'b1) begin
         n_fail++;
         $display("FAIL oneshot_exp_irq: status=%h irq=%b required 1/1", bus.dataout, bus.irq);
      end
      bus_cycle(A_CTRL, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd4) begin
         n_fail++;
         $display("FAIL oneshot_en_clear: ctrl=%h required 4", bus.dataout);
      end
      bus_cycle(A_COUNT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd0) begin
         n_fail++;
         $display("FAIL oneshot_count_hold: count=%h required 0", bus.dataout);
      end
      // W1C after a one-shot expiry: EXP clears, irq follows one clock later.
      bus_cycle(A_STAT, 1'b1, 32'd1);
      bus_cycle(A_STAT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd0 || bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_w1c: status=%h irq=%b required 0/0", bus.dataout, bus.irq);
      end
      $display("oneshot done");
   endtask

   task automatic test_autoreload();
      logic [31:0] exp_seq [6] = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
      bus_cycle(A_LOAD, 1'b1, 32'd2);
      bus_cycle(A_CTRL, 1'b1, 32'd3);
      for (int i = 0; i < 6; i++) begin
         bus_cycle(A_COUNT, 1'b0, 32'd0);
         n_checks++;
         if (bus.dataout !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL auto_count[%0d]: dataout=%h required %h", i, bus.dataout, exp_seq[i]);
         end
      end
      bus_cycle(A_STAT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd1) begin
         n_fail++;
         $display("FAIL auto_exp: status=%h required 1", bus.dataout);
      end
      $display("autoreload done");
   endtask

   task automatic test_w1c_collision();
      bus_cycle(A_CTRL, 1'b1, 32'd0);
      bus_cycle(A_LOAD, 1'b1, 32'd0);
      bus_cycle(A_CTRL, 1'b1, 32'd3);
      bus_cycle(A_STAT, 1'b1, 32'd1);
      bus_cycle(A_STAT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'd1 || bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_collision: status=%h irq=%b required 1/0", bus.dataout, bus.irq);
      end
      bus_cycle(A_CTRL, 1'b1, 32'd0);
      $display("w1c collision done");
   endtask

   task automatic test_edge_values();
      bus_cycle(A_LOAD, 1'b1, 32'hFFFF_FFFF);
      bus_cycle(A_CTRL, 1'b1, 32'd1);
      bus_cycle(A_COUNT, 1'b0, 32'd0);
      bus_cycle(A_COUNT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL full_range: count=%h required fffffffe", bus.dataout);
      end
      // The disabling edge still decrements because EN was 1 going into it.
      bus_cycle(A_CTRL, 1'b1, 32'd0);
      bus_cycle(A_COUNT, 1'b1, 32'd7);
      bus_cycle(A_COUNT, 1'b0, 32'd0);
      n_checks++;
      if (bus.dataout !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL count_ro: count=%h required fffffffc", bus.dataout);
      end
      $display("edge values done");
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic        w, exp_hit;
      bus_cycle(A_STAT, 1'b1, 32'd1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         w = ($urandom_range(0, 3) == 0);
         case (a[3:2])
            2'd0: d = {$urandom_range(0, 1) ? 29'h0 : 29'($urandom), 3'($urandom)};
            2'd1: d = 32'($urandom_range(0, 6));
            default: d = $urandom;
         endcase
         bus.address = a; bus.wr = w; bus.datain = d;
         #1;
         exp_hit = (a[31:4] == BASE[31:4]);
         n_checks++;
         if (bus.hit !== exp_hit) begin
            n_fail++;
            $display("FAIL rand_hit[%0d]: hit=%b required %b", i, bus.hit, exp_hit);
         end
         bus_cycle(a, w, d);
         n_checks++;
         if (bus.dataout !== m_dout || bus.irq !== m_irq) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: addr=%h wr=%b dataout=%h irq=%b required %h/%b",
                     i, a, w, bus.dataout, bus.irq, m_dout, m_irq);
         end
      end
      $display("random done");
   endtask

   task automatic test_reset_midcount();
      bit reached = 1'b0;
      bus_cycle(A_CTRL, 1'b1, 32'd0);
      bus_cycle(A_LOAD, 1'b1, 32'd100);
      bus_cycle(A_CTRL, 1'b1, 32'd1);
      for (int i = 0; i < 200 && !reached; i++) begin
         bus_cycle(A_COUNT, 1'b0, 32'd0);
         if (m_count == 32'd50) reached = 1'b1;
      end
      n_checks++;
      if (!reached) begin
         n_fail++;
         $display("FAIL midcount_timeout: count=%0d required 50", m_count);
      end
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (bus.dataout !== 32'd0 || bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL midcount_async: dataout=%h irq=%b required 0/0", bus.dataout, bus.irq);
      end
      #2 reset = 1'b1;
      for (int r = 0; r < 4; r++) begin
         bus_cycle(BASE + 32'(r * 4), 1'b0, 32'd0);
         n_checks++;
         if (bus.dataout !== 32'd0) begin
            n_fail++;
            $display("FAIL midcount_reg[%0d]: dataout=%h required 0", r, bus.dataout);
         end
      end
      $display("reset midcount done");
   endtask

   initial begin
      test_reset();
      test_readback();
      test_oneshot();
      test_autoreload();
      test_w1c_collision();
      test_edge_values();
      test_random();
      test_reset_midcount();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
